// File: rtl/piso_shift_reg_param_if.sv
// Load handshake and serial-side bundle for the parametrised PISO.
// master = word source / link driver, slave = the shift register.
interface piso_shift_reg_param_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             shift_en;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output load_valid,
    output parallel_in,
    output shift_en,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  frame_start,
    input  frame_done,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  parallel_in,
    input  shift_en,
    output load_ready,
    output serial_out,
    output serial_valid,
    output frame_start,
    output frame_done,
    output busy
  );
endinterface

// File: rtl/piso_shift_reg_param.sv
// Parametrised parallel-in/serial-out shift register with valid/ready
// load, shift stall, frame status pulses and gapless back-to-back frames.
module piso_shift_reg_param #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  piso_shift_reg_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sval_q, sval_d;
  logic             fs_q, fs_d;
  logic             fd_q, fd_d;

  logic             last;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;

  assign last = (cnt_q == CW'(WIDTH - 1));

  assign bus.load_ready = (state_q == IDLE)
                        | ((state_q == SHIFT) & last & bus.shift_en);

  assign accept = bus.load_valid & bus.load_ready;

  // shreg keeps the current bit at its outgoing end; next bit sits one in
  assign first_bit = MSB_FIRST ? bus.parallel_in[WIDTH-1]
                               : bus.parallel_in[0];
  assign next_bit  = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
  assign shifted   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    sval_d  = sval_q;
    fs_d    = 1'b0;
    fd_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        sout_d = IDLE_LEVEL;
        sval_d = 1'b0;
        if (accept) begin
          shreg_d = bus.parallel_in;
          sout_d  = first_bit;
          sval_d  = 1'b1;
          fs_d    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (!last) begin
            shreg_d = shifted;
            sout_d  = next_bit;
            cnt_d   = cnt_q + CW'(1);
          end else begin
            fd_d = 1'b1;
            if (accept) begin
              shreg_d = bus.parallel_in;
              sout_d  = first_bit;
              sval_d  = 1'b1;
              fs_d    = 1'b1;
              cnt_d   = '0;
            end else begin
              sout_d  = IDLE_LEVEL;
              sval_d  = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sout_q  <= IDLE_LEVEL;
      sval_q  <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      sval_q  <= sval_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.serial_out   = sout_q;
  assign bus.serial_valid = sval_q;
  assign bus.frame_start  = fs_q;
  assign bus.frame_done   = fd_q;
  assign bus.busy         = (state_q == SHIFT);
endmodule

// File: tb/tb_piso_shift_reg_param.sv
// Bench for piso_shift_reg_param: MSB-first and LSB-first instances
// share stimulus and are checked against a queue-based frame model.
module tb_piso_shift_reg_param;
  localparam int W    = 4;
  localparam bit IDLE = 1'b0;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] parallel_in;
  logic         shift_en;

  int checks = 0;
  int errors = 0;

  piso_shift_reg_param_if #(.WIDTH(W)) if_m ();
  piso_shift_reg_param_if #(.WIDTH(W)) if_l ();

  assign if_m.load_valid  = load_valid;
  assign if_m.parallel_in = parallel_in;
  assign if_m.shift_en    = shift_en;
  assign if_l.load_valid  = load_valid;
  assign if_l.parallel_in = parallel_in;
  assign if_l.shift_en    = shift_en;

  piso_shift_reg_param #(
    .WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE)
  ) dut_m (
    .clk(clk), .rst(rst), .bus(if_m)
  );

  piso_shift_reg_param #(
    .WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE)
  ) dut_l (
    .clk(clk), .rst(rst), .bus(if_l)
  );

  always #5 clk = ~clk;

  // model: queues of bits still to be shown, front = bit on the wire
  bit   mq[$];
  bit   lq[$];
  bit   m_busy = 1'b0;
  bit   m_fs   = 1'b0;
  bit   m_fd   = 1'b0;
  bit   last_acc;
  logic [7:0] seq_m, seq_l;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return !m_busy || (mq.size() == 1 && shift_en);
  endfunction

  task automatic tick();
    bit r, acc, rs, se;
    logic [W-1:0] w;
    #1;
    r = model_ready();
    check("ready_m", {7'b0, if_m.load_ready}, {7'b0, r});
    check("ready_l", {7'b0, if_l.load_ready}, {7'b0, r});
    acc = load_valid && r;
    rs  = rst;
    se  = shift_en;
    w   = parallel_in;
    @(posedge clk);
    m_fs = 1'b0;
    m_fd = 1'b0;
    last_acc = 1'b0;
    if (!rs) begin
      mq.delete();
      lq.delete();
      m_busy = 1'b0;
    end else begin
      if (m_busy && se) begin
        void'(mq.pop_front());
        void'(lq.pop_front());
        if (mq.size() == 0) begin
          m_fd   = 1'b1;
          m_busy = 1'b0;
        end
      end
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) mq.push_back(w[i]);
        for (int i = 0; i < W; i++) lq.push_back(w[i]);
        m_busy   = 1'b1;
        m_fs     = 1'b1;
        last_acc = 1'b1;
      end
    end
    @(negedge clk);
    check("sout_m", {7'b0, if_m.serial_out},
          {7'b0, m_busy ? mq[0] : IDLE});
    check("sout_l", {7'b0, if_l.serial_out},
          {7'b0, m_busy ? lq[0] : IDLE});
    check("sval_m", {7'b0, if_m.serial_valid}, {7'b0, m_busy});
    check("sval_l", {7'b0, if_l.serial_valid}, {7'b0, m_busy});
    check("fs_m", {7'b0, if_m.frame_start}, {7'b0, m_fs});
    check("fs_l", {7'b0, if_l.frame_start}, {7'b0, m_fs});
    check("fd_m", {7'b0, if_m.frame_done}, {7'b0, m_fd});
    check("fd_l", {7'b0, if_l.frame_done}, {7'b0, m_fd});
    check("busy_m", {7'b0, if_m.busy}, {7'b0, m_busy});
    check("busy_l", {7'b0, if_l.busy}, {7'b0, m_busy});
  endtask

  task automatic rec();
    seq_m = {seq_m[6:0], if_m.serial_out};
    seq_l = {seq_l[6:0], if_l.serial_out};
  endtask

  initial begin
    rst         = 1'b0;
    load_valid  = 1'b1;
    parallel_in = 4'b1011;
    shift_en    = 1'b1;
    seq_m       = '0;
    seq_l       = '0;
    @(negedge clk);

    // reset held with a word on offer: nothing may be captured
    tick();
    tick();
    check("rst_busy", {7'b0, if_m.busy}, 8'd0);
    rst        = 1'b1;
    load_valid = 1'b0;
    tick();
    check("rst_idle_sv", {7'b0, if_m.serial_valid}, 8'd0);

    // single frame, both bit orders
    load_valid = 1'b1;
    parallel_in = 4'b1011;
    tick();
    load_valid = 1'b0;
    rec();
    repeat (3) begin tick(); rec(); end
    check("seq_msb", {4'b0, seq_m[3:0]}, 8'b1011);
    check("seq_lsb", {4'b0, seq_l[3:0]}, 8'b1101);
    tick();
    check("done_pulse", {7'b0, if_m.frame_done}, 8'd1);
    tick();

    // back-to-back frames with no gap
    load_valid  = 1'b1;
    parallel_in = 4'b1011;
    tick();
    rec();
    parallel_in = 4'b0110;
    repeat (3) begin tick(); rec(); end
    tick();
    rec();
    check("boundary", {6'b0, if_m.frame_start, if_m.frame_done}, 8'b11);
    load_valid = 1'b0;
    repeat (3) begin tick(); rec(); end
    check("seq_b2b", seq_m, 8'b10110110);
    tick();
    tick();

    // shift stall after bit 2
    load_valid  = 1'b1;
    parallel_in = 4'b1011;
    tick();
    rec();
    load_valid = 1'b0;
    tick();
    rec();
    shift_en = 1'b0;
    repeat (3) begin tick(); rec(); end
    shift_en = 1'b1;
    tick(); rec();
    tick(); rec();
    check("seq_stall", {1'b0, seq_m[6:0]}, 8'b01000011);
    tick();
    tick();

    // reset during bit 3 aborts the frame
    load_valid  = 1'b1;
    parallel_in = 4'b1011;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("abort_sv", {7'b0, if_m.serial_valid}, 8'd0);
    rst = 1'b1;
    tick();
    check("abort_fd", {7'b0, if_m.frame_done}, 8'd0);
    load_valid  = 1'b1;
    parallel_in = 4'b0110;
    tick();
    load_valid = 1'b0;
    rec();
    repeat (3) begin tick(); rec(); end
    check("seq_fresh", {4'b0, seq_m[3:0]}, 8'b0110);
    tick();

    // randomized traffic, source holds its word until accepted
    last_acc = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (last_acc || !load_valid) parallel_in = W'($urandom);
      load_valid = ($urandom_range(0, 2) != 0);
      shift_en   = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 59) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
